mod_exp: RTL and testbench

Sequential RSA modular-exponentiation engine computing result = base^exp mod n on 32-bit operands. It is the requester that drives modular multiplications: left-to-right square-and-multiply over the exponent, issuing one modular multiply at a time to an internal bit-serial multiply-reduce unit. It sits above the modular-multiply datapath and is what the RSA encrypt/decrypt top level calls with a start/done handshake.

---
 rtl/rsa_pkg.sv | 28 ++
 rtl/mod_mul_seq.sv | 79 +++++++
 rtl/mod_exp.sv | 190 +++++++++++++++++++
 tb/tb_mod_exp.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// rsa_pkg: shared types and constants for the modular-exponentiation engine.
// Holds the operand width, top FSM state encoding and cycle-count constants
// (multiply-unit latency, per-mulmod cost and end-to-end latency helpers).
package rsa_pkg;

  localparam int WORD_W     = 32;
  localparam int IDX_W      = 5;
  // Multiply unit: start edge plus one edge per bit, done flag the cycle after.
  localparam int MM_LAT     = 33;
  // One issue cycle in the top FSM plus the unit latency.
  localparam int MULMOD_CYC = MM_LAT + 1;
  // Constant-time build: LOAD plus a square and a multiply for every bit.
  localparam int LAT_CONST  = MULMOD_CYC * 65 + 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SQR,
    MUL,
    FIN
  } state_t;

  // Data-dependent latency: LOAD + 32 squares + one multiply per set bit.
  function automatic int lat_var(input int popcnt);
    return MULMOD_CYC * (33 + popcnt) + 1;
  endfunction

endpackage

// File: rtl/mod_mul_seq.sv
// mod_mul_seq: bit-serial modular multiply, mm_r = a*b mod n (requires a < n).
// Ports: clk, reset (async active-low), mm_start/a/b/n in; mm_done pulse, mm_r out.
// Operands latched when mm_start is sampled; 32 iterations MSB of b first; mm_done
// is high for one cycle after the last iteration and mm_r holds until next start.
module mod_mul_seq
  import rsa_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              mm_start,
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic [WORD_W-1:0] n,
  output logic              mm_done,
  output logic [WORD_W-1:0] mm_r
);

  logic [WORD_W-1:0] a_q, a_d;
  logic [WORD_W-1:0] b_q, b_d;
  logic [WORD_W-1:0] n_q, n_d;
  logic [WORD_W-1:0] r_q, r_d;
  logic [5:0]        cnt_q, cnt_d;
  logic              done_q, done_d;

  // 2r + a < 3n < 2^34, so two spare bits cover every intermediate value.
  logic [WORD_W+1:0] t;
  logic [WORD_W+1:0] n1;
  logic [WORD_W+1:0] n2;

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    n_d    = n_q;
    r_d    = r_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    t      = {1'b0, r_q, 1'b0} + (b_q[WORD_W-1] ? {2'b00, a_q} : '0);
    n1     = {2'b00, n_q};
    n2     = {1'b0, n_q, 1'b0};

    if (mm_start) begin
      a_d   = a;
      b_d   = b;
      n_d   = n;
      r_d   = '0;
      cnt_d = 6'(WORD_W);
    end else if (cnt_q != '0) begin
      // Subtracting n at most twice is the same as picking t-2n, t-n or t.
      if (t >= n2)      r_d = WORD_W'(t - n2);
      else if (t >= n1) r_d = WORD_W'(t - n1);
      else              r_d = WORD_W'(t);
      b_d    = {b_q[WORD_W-2:0], 1'b0};
      cnt_d  = cnt_q - 6'd1;
      done_d = (cnt_q == 6'd1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q    <= '0;
      b_q    <= '0;
      n_q    <= '0;
      r_q    <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      n_q    <= n_d;
      r_q    <= r_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign mm_done = done_q;
  assign mm_r    = r_q;

endmodule

// File: rtl/mod_exp.sv
// mod_exp: result = base^exp mod n by left-to-right square-and-multiply.
// Ports: clk, reset (async active-low), start/base/exp/n in; result/done/busy/err out.
// MOD_EXP_CONST_TIME_EN: run the multiply for every exponent bit (discarding it
// into a dummy register when the bit is 0) so latency does not depend on exp.
module mod_exp
  import rsa_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WORD_W-1:0] base,
  input  logic [WORD_W-1:0] exp,
  input  logic [WORD_W-1:0] n,
  output logic [WORD_W-1:0] result,
  output logic              done,
  output logic              busy,
  output logic              err
);

  state_t            state_q, state_d;
  logic              issued_q, issued_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WORD_W-1:0] base_q, base_d;
  logic [WORD_W-1:0] exp_q, exp_d;
  logic [WORD_W-1:0] n_q, n_d;
  logic [WORD_W-1:0] b_r_q, b_r_d;
  logic [WORD_W-1:0] acc_q, acc_d;
  logic [WORD_W-1:0] result_q, result_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
`ifdef MOD_EXP_CONST_TIME_EN
  logic [WORD_W-1:0] dummy_q, dummy_d;
`endif

  logic              mm_start;
  logic [WORD_W-1:0] mm_a;
  logic [WORD_W-1:0] mm_b;
  logic              mm_done;
  logic [WORD_W-1:0] mm_r;
  logic              mul_needed;

  mod_mul_seq u_mm (
    .clk      (clk),
    .reset    (reset),
    .mm_start (mm_start),
    .a        (mm_a),
    .b        (mm_b),
    .n        (n_q),
    .mm_done  (mm_done),
    .mm_r     (mm_r)
  );

  always_comb begin
    state_d  = state_q;
    issued_d = issued_q;
    idx_d    = idx_q;
    base_d   = base_q;
    exp_d    = exp_q;
    n_d      = n_q;
    b_r_d    = b_r_q;
    acc_d    = acc_q;
    result_d = result_q;
    done_d   = 1'b0;
    err_d    = err_q;
`ifdef MOD_EXP_CONST_TIME_EN
    dummy_d    = dummy_q;
    mul_needed = 1'b1;
`else
    mul_needed = exp_q[idx_q];
`endif
    mm_start = 1'b0;
    mm_a     = acc_q;
    mm_b     = acc_q;

    // Every mulmod state spends one cycle issuing, then waits for mm_done.
    if (state_q == LOAD || state_q == SQR || state_q == MUL) begin
      if (!issued_q) begin
        mm_start = 1'b1;
        issued_d = 1'b1;
      end else if (mm_done) begin
        issued_d = 1'b0;
      end
    end

    case (state_q)
      IDLE: begin
        // The done cycle still counts as busy, so a start there is dropped.
        if (start && !done_q) begin
          base_d   = base;
          exp_d    = exp;
          n_d      = n;
          err_d    = 1'b0;
          idx_d    = IDX_W'(WORD_W - 1);
          issued_d = 1'b0;
          if (n == '0) begin
            acc_d   = '0;
            state_d = FIN;
          end else begin
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        // 1*base reduces a base that may be >= n.
        mm_a = WORD_W'(1);
        mm_b = base_q;
        if (issued_q && mm_done) begin
          b_r_d   = mm_r;
          acc_d   = (n_q == WORD_W'(1)) ? '0 : WORD_W'(1);
          state_d = SQR;
        end
      end
      SQR: begin
        if (issued_q && mm_done) begin
          acc_d = mm_r;
          if (mul_needed)          state_d = MUL;
          else if (idx_q == '0)    state_d = FIN;
          else begin
            idx_d   = idx_q - IDX_W'(1);
            state_d = SQR;
          end
        end
      end
      MUL: begin
        mm_b = b_r_q;
        if (issued_q && mm_done) begin
`ifdef MOD_EXP_CONST_TIME_EN
          if (exp_q[idx_q]) acc_d   = mm_r;
          else              dummy_d = mm_r;
`else
          acc_d = mm_r;
`endif
          if (idx_q == '0) state_d = FIN;
          else begin
            idx_d   = idx_q - IDX_W'(1);
            state_d = SQR;
          end
        end
      end
      FIN: begin
        result_d = acc_q;
        err_d    = (n_q == '0);
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      issued_q <= 1'b0;
      idx_q    <= '0;
      base_q   <= '0;
      exp_q    <= '0;
      n_q      <= '0;
      b_r_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef MOD_EXP_CONST_TIME_EN
      dummy_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      issued_q <= issued_d;
      idx_q    <= idx_d;
      base_q   <= base_d;
      exp_q    <= exp_d;
      n_q      <= n_d;
      b_r_q    <= b_r_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      done_q   <= done_d;
      err_q    <= err_d;
`ifdef MOD_EXP_CONST_TIME_EN
      dummy_q  <= dummy_d;
`endif
    end
  end

  assign result = result_q;
  assign done   = done_q;
  assign err    = err_q;
  // done is registered out of FIN, so busy covers the done cycle via done_q.
  assign busy   = (state_q != IDLE) || done_q;

endmodule

// File: tb/tb_mod_exp.sv
// tb_mod_exp: directed and random jobs against a 64-bit arithmetic model of
// base^exp mod n, checking result, err, done latency, busy and reset behaviour.
module tb_mod_exp;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] base;
  logic [31:0] exp_i;
  logic [31:0] n;
  logic [31:0] result;
  logic        done;
  logic        busy;
  logic        err;

  int total = 0;
  int bad   = 0;

  mod_exp dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .base   (base),
    .exp    (exp_i),
    .n      (n),
    .result (result),
    .done   (done),
    .busy   (busy),
    .err    (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Right-to-left binary exponentiation with native 64-bit products.
  function automatic logic [31:0] ref_modexp(input logic [31:0] b, input logic [31:0] e,
                                             input logic [31:0] nn);
    longint unsigned m, r, x;
    if (nn == 0) return 32'd0;
    m = 64'(nn);
    r = 64'd1 % m;
    x = 64'(b) % m;
    for (int i = 0; i < 32; i++) begin
      if (e[i]) r = (r * x) % m;
      x = (x * x) % m;
    end
    return r[31:0];
  endfunction

  // Edges from the start-sampling edge to the edge that raises done.
  function automatic int ref_lat(input logic [31:0] e, input logic [31:0] nn);
    if (nn == 0) return 1;
`ifdef MOD_EXP_CONST_TIME_EN
    return 2211;
`else
    return 34 * (1 + 32 + $countones(e)) + 1;
`endif
  endfunction

  // Runs one job; if poke_at > 0 a second start with scrambled operands is
  // pulsed that many edges into the job and must have no effect.
  task automatic run_job(input string tag, input logic [31:0] b, input logic [31:0] e,
                         input logic [31:0] nn, input int poke_at);
    int cyc;
    int extra;
    logic [31:0] want;
    want = ref_modexp(b, e, nn);
    @(posedge clk); #1;
    base = b; exp_i = e; n = nn; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, ".busy_start"}, 32'(busy), 32'd1);
    check({tag, ".err_clr"}, 32'(err), 32'd0);
    cyc = 0;
    while (!done && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      if (poke_at > 0 && cyc == poke_at) begin
        start = 1'b1; base = ~b; exp_i = ~e; n = nn ^ 32'h5;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check({tag, ".lat"}, 32'(cyc), 32'(ref_lat(e, nn)));
    check({tag, ".result"}, result, want);
    check({tag, ".err"}, 32'(err), (nn == 0) ? 32'd1 : 32'd0);
    @(posedge clk); #1;
    check({tag, ".busy_fall"}, 32'(busy), 32'd0);
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) extra++;
      @(posedge clk); #1;
    end
    check({tag, ".extra_done"}, 32'(extra), 32'd0);
    check({tag, ".result_hold"}, result, want);
  endtask

  initial begin
    int cyc;
    int stray;
    logic [31:0] rb, re, rn;

    reset = 1'b0; start = 1'b0; base = '0; exp_i = '0; n = '0;
    #1;
    check("rst.result", result, 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.err", 32'(err), 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    run_job("t4_13", 32'd4, 32'd13, 32'd497, 0);
    check("t4_13.known", result, 32'd445);
    run_job("big_base", 32'd1000, 32'd1, 32'd497, 0);
    run_job("max_ops", 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFB, 0);
    check("max_ops.known", result, 32'd16);
    run_job("exp0", 32'd12345, 32'd0, 32'd497, 0);
    run_job("n1", 32'd77, 32'd5, 32'd1, 0);
    run_job("n0", 32'd9, 32'd3, 32'd0, 0);
    run_job("after_n0", 32'd2, 32'd10, 32'd1000, 0);
    run_job("ignore_start", 32'd4, 32'd13, 32'd497, 100);

    for (int k = 0; k < 4; k++) begin
      rb = $urandom; re = $urandom; rn = $urandom;
      if (rn == 0) rn = 32'd3;
      run_job("rand_big", rb, re, rn, 0);
    end
    for (int k = 0; k < 3; k++) begin
      rb = $urandom; re = $urandom; rn = $urandom_range(2, 1000);
      run_job("rand_small", rb, re, rn, 0);
    end

    // Abort a running job with reset partway through.
    @(posedge clk); #1;
    base = 32'd4; exp_i = 32'hFFFF_FFFF; n = 32'd497; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (cyc < 500) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("abort.busy_before", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check("abort.result", result, 32'd0);
    check("abort.done", 32'(done), 32'd0);
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.err", 32'(err), 32'd0);
    stray = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done || busy) stray++;
    end
    reset = 1'b1;
    for (int i = 0; i < 2400; i++) begin
      @(posedge clk); #1;
      if (done || busy) stray++;
    end
    check("abort.stray", 32'(stray), 32'd0);
    run_job("post_abort", 32'd3, 32'd200, 32'd101, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
